// File: rtl/fifo_pop_engine.sv
// Command sequencer for the 8-entry shift-register FIFO: owns the mode bus and the popped-entry output slice.
// Build option AUTO_DRAIN_EN: pop whenever possible instead of once per synchronized pop_btn press.
module fifo_pop_engine #(
    parameter int WIDTH        = 8,
    parameter int FLUSH_CYCLES = 2
) (
    input  logic             gclk,
    input  logic             rst_n,
    input  logic             wr_req,
    input  logic             flush_req,
    input  logic             pop_btn,
    input  logic             fifo_empty,
    input  logic             fifo_full,
    input  logic [WIDTH-1:0] fifo_head,
    output logic [1:0]       mode,
    output logic             rd_valid,
    output logic [WIDTH-1:0] rd_data,
    input  logic             rd_ready,
    output logic             wr_drop,
    output logic [7:0]       pop_count
);

    localparam int CW = $clog2(FLUSH_CYCLES + 1);
    localparam logic [1:0] M_HOLD = 2'b00, M_IN = 2'b01, M_OUT = 2'b10, M_RST = 2'b11;

    typedef enum logic [1:0] {FLUSH, IDLE, POP, SETTLE} state_t;

    state_t          state, state_nxt;
    logic [CW-1:0]   flush_cnt, cnt_nxt;
    logic [1:0]      mode_nxt;
    logic            drop_nxt, load, enter_flush, wr_ok, pop_ok, trig;

`ifdef AUTO_DRAIN_EN
    logic unused_btn;
    assign unused_btn = pop_btn;
    assign trig       = 1'b1;
`else
    logic [1:0] sync;
    logic       pop_pend;
    logic       rise;

    // pop_pend samples the first stage alongside sync[1], so it is itself a second synchronizer flop.
    assign rise = sync[0] & ~sync[1];
    assign trig = pop_pend;

    always_ff @(posedge gclk or negedge rst_n) begin
        if (!rst_n) begin
            sync     <= 2'b00;
            pop_pend <= 1'b0;
        end else begin
            sync <= {sync[0], pop_btn};
            if (load || fifo_empty)
                pop_pend <= 1'b0;
            else if (rise)
                pop_pend <= 1'b1;
        end
    end
`endif

    assign wr_ok  = wr_req && !fifo_full && (mode != M_IN);
    assign pop_ok = !fifo_empty && (!rd_valid || rd_ready) && (mode == M_HOLD) && trig;

    always_comb begin
        state_nxt   = state;
        cnt_nxt     = flush_cnt;
        mode_nxt    = M_HOLD;
        drop_nxt    = 1'b0;
        load        = 1'b0;
        enter_flush = 1'b0;
        case (state)
            FLUSH: begin
                mode_nxt = M_RST;
                drop_nxt = wr_req;
                if (flush_req)
                    cnt_nxt = CW'(FLUSH_CYCLES);
                else if (flush_cnt == CW'(1)) begin
                    state_nxt = IDLE;
                    mode_nxt  = M_HOLD;
                end else
                    cnt_nxt = flush_cnt - CW'(1);
            end
            IDLE: begin
                if (flush_req)
                    enter_flush = 1'b1;
                else if (wr_req) begin
                    // a refused write still owns this cycle; any pending pop waits
                    mode_nxt = wr_ok ? M_IN : M_HOLD;
                    drop_nxt = !wr_ok;
                end else if (pop_ok) begin
                    state_nxt = POP;
                    mode_nxt  = M_OUT;
                    load      = 1'b1;
                end
            end
            POP: begin
                drop_nxt = wr_req;
                if (flush_req)
                    enter_flush = 1'b1;
                else
                    state_nxt = SETTLE;
            end
            SETTLE: begin
                if (flush_req)
                    enter_flush = 1'b1;
                else begin
                    state_nxt = IDLE;
                    mode_nxt  = wr_ok ? M_IN : M_HOLD;
                    drop_nxt  = wr_req && !wr_ok;
                end
            end
            default: state_nxt = FLUSH;
        endcase
        if (enter_flush) begin
            state_nxt = FLUSH;
            cnt_nxt   = CW'(FLUSH_CYCLES);
            mode_nxt  = M_RST;
            drop_nxt  = wr_req;
        end
    end

    always_ff @(posedge gclk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= FLUSH;
            flush_cnt <= CW'(FLUSH_CYCLES);
            mode      <= M_RST;
            wr_drop   <= 1'b0;
            pop_count <= 8'd0;
            rd_valid  <= 1'b0;
            rd_data   <= '0;
        end else begin
            state     <= state_nxt;
            flush_cnt <= cnt_nxt;
            mode      <= mode_nxt;
            wr_drop   <= drop_nxt;
            if (state == POP)
                pop_count <= pop_count + 8'd1;
            // load wins over consume so a ready consumer sees back-to-back entries
            if (enter_flush)
                rd_valid <= 1'b0;
            else if (load) begin
                rd_valid <= 1'b1;
                rd_data  <= fifo_head;
            end else if (rd_valid && rd_ready)
                rd_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_fifo_pop_engine.sv
// Bench for fifo_pop_engine: directed vector table, reset/wrap sequences, then random traffic against a FIFO + engine model.
module tb_fifo_pop_engine;

    localparam int FLUSH_CYCLES = 2;

    logic       gclk = 1'b0;
    logic       rst_n = 1'b0;
    logic       wr_req = 1'b0, flush_req = 1'b0, pop_btn = 1'b0;
    logic       fifo_empty = 1'b1, fifo_full = 1'b0, rd_ready = 1'b1;
    logic [7:0] fifo_head = 8'h00;
    logic [1:0] mode;
    logic       rd_valid, wr_drop;
    logic [7:0] rd_data, pop_count;

    int tests = 0;
    int fails = 0;

    fifo_pop_engine #(.WIDTH(8), .FLUSH_CYCLES(FLUSH_CYCLES)) dut (
        .gclk(gclk), .rst_n(rst_n), .wr_req(wr_req), .flush_req(flush_req), .pop_btn(pop_btn),
        .fifo_empty(fifo_empty), .fifo_full(fifo_full), .fifo_head(fifo_head), .mode(mode),
        .rd_valid(rd_valid), .rd_data(rd_data), .rd_ready(rd_ready), .wr_drop(wr_drop),
        .pop_count(pop_count)
    );

    always #5 gclk = ~gclk;

    typedef struct packed {
        logic       wr, fl, btn, rdy, emp, full;
        logic [7:0] head;
        logic [1:0] e_mode;
        logic       e_vld;
        logic [7:0] e_data;
        logic       e_drop;
        logic [7:0] e_pc;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(logic wr, logic fl, logic btn, logic rdy, logic emp, logic full,
                                logic [7:0] head, logic [1:0] m, logic v, logic [7:0] d,
                                logic dr, logic [7:0] pc);
        vec_t r;
        r = '{wr, fl, btn, rdy, emp, full, head, m, v, d, dr, pc};
        return r;
    endfunction

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %h, expected %h", name, got, exp);
        end
    endtask

    task automatic step();
        @(posedge gclk);
        #1;
    endtask

    // Packs the observable outputs; rd_data only matters while the slice holds an entry.
    function automatic logic [31:0] pack(logic [1:0] m, logic v, logic [7:0] d, logic dr, logic [7:0] pc);
        return {12'h0, m, v, (v ? d : 8'h00), dr, pc};
    endfunction

    // ---------------- reference model ----------------
    int         m_flush_left;
    bit         m_pop, m_settle, m_vld, m_drop, m_pend, m_b1, m_b2;
    logic [1:0] m_mode;
    logic [7:0] m_data, m_pc;
    logic [7:0] q[$];

    task automatic model_reset();
        m_flush_left = FLUSH_CYCLES;
        m_pop = 0; m_settle = 0; m_vld = 0; m_drop = 0; m_pend = 0; m_b1 = 0; m_b2 = 0;
        m_mode = 2'b11; m_data = 8'h00; m_pc = 8'h00;
    endtask

    task automatic model_step();
        logic [1:0] old_mode;
        bit rise, trig, loaded, to_flush, accept, was_settle;
        old_mode = m_mode;
        rise = m_b1 && !m_b2;
`ifdef AUTO_DRAIN_EN
        trig = 1;
`else
        trig = m_pend;
`endif
        loaded = 0; to_flush = 0; accept = 0;
        if (m_flush_left > 0) begin
            if (flush_req) m_flush_left = FLUSH_CYCLES;
            else m_flush_left--;
            m_mode = (m_flush_left == 0) ? 2'b00 : 2'b11;
        end else if (m_pop) begin
            m_pop = 0;
            m_pc = m_pc + 8'd1;
            m_mode = 2'b00;
            if (flush_req) to_flush = 1; else m_settle = 1;
        end else begin
            was_settle = m_settle;
            m_settle = 0;
            m_mode = 2'b00;
            if (flush_req) to_flush = 1;
            else if (wr_req) begin
                accept = !fifo_full && old_mode != 2'b01;
                if (accept) m_mode = 2'b01;
            end else if (!was_settle && !fifo_empty && (!m_vld || rd_ready) && old_mode == 2'b00 && trig) begin
                m_pop = 1;
                m_mode = 2'b10;
                loaded = 1;
            end
        end
        m_drop = wr_req && !accept;
        if (to_flush) begin
            m_flush_left = FLUSH_CYCLES;
            m_mode = 2'b11;
            m_vld = 0;
        end else if (loaded) begin
            m_vld = 1;
            m_data = fifo_head;
        end else if (m_vld && rd_ready) m_vld = 0;
        if (loaded || fifo_empty) m_pend = 0;
        else if (rise) m_pend = 1;
        m_b2 = m_b1;
        m_b1 = pop_btn;
    endtask

    task automatic drive_fifo_flags();
        fifo_empty = (q.size() == 0);
        fifo_full  = (q.size() == 8);
        fifo_head  = (q.size() == 0) ? 8'h00 : q[0];
    endtask

    initial begin
        // wr fl btn rdy emp full head | mode vld data drop pc
        tbl.push_back(mk(0,0,0,1,0,0,8'hA5, 2'b11,0,8'h00,0,8'd0));
        tbl.push_back(mk(0,0,0,1,0,0,8'hA5, 2'b00,0,8'h00,0,8'd0));
        tbl.push_back(mk(0,0,1,1,0,0,8'hA5, 2'b00,0,8'h00,0,8'd0));
        tbl.push_back(mk(0,0,1,1,0,0,8'hA5, 2'b00,0,8'h00,0,8'd0));
        tbl.push_back(mk(0,0,1,1,0,0,8'hA5, 2'b10,1,8'hA5,0,8'd0));
        tbl.push_back(mk(0,0,1,0,0,0,8'h3C, 2'b00,1,8'hA5,0,8'd1));
        tbl.push_back(mk(0,0,1,1,0,0,8'h3C, 2'b00,0,8'h00,0,8'd1));
        tbl.push_back(mk(0,0,1,1,0,0,8'h3C, 2'b00,0,8'h00,0,8'd1));
        tbl.push_back(mk(1,0,0,1,0,0,8'h3C, 2'b01,0,8'h00,0,8'd1));
        tbl.push_back(mk(1,0,0,1,0,0,8'h3C, 2'b00,0,8'h00,1,8'd1));
        tbl.push_back(mk(1,0,0,1,0,0,8'h3C, 2'b01,0,8'h00,0,8'd1));
        tbl.push_back(mk(1,0,0,1,0,0,8'h3C, 2'b00,0,8'h00,1,8'd1));
        tbl.push_back(mk(1,0,0,1,0,1,8'h3C, 2'b00,0,8'h00,1,8'd1));
        tbl.push_back(mk(1,0,0,1,0,1,8'h3C, 2'b00,0,8'h00,1,8'd1));
        tbl.push_back(mk(0,0,1,1,0,0,8'h3C, 2'b00,0,8'h00,0,8'd1));
        tbl.push_back(mk(0,0,1,1,0,0,8'h3C, 2'b00,0,8'h00,0,8'd1));
        tbl.push_back(mk(1,0,1,1,0,0,8'h3C, 2'b01,0,8'h00,0,8'd1));
        tbl.push_back(mk(0,0,1,1,0,0,8'h3C, 2'b00,0,8'h00,0,8'd1));
        tbl.push_back(mk(0,0,1,1,0,0,8'hC3, 2'b10,1,8'hC3,0,8'd1));
        tbl.push_back(mk(0,0,0,0,0,0,8'hC3, 2'b00,1,8'hC3,0,8'd2));
        tbl.push_back(mk(0,1,0,0,0,0,8'hC3, 2'b11,0,8'h00,0,8'd2));
        tbl.push_back(mk(1,0,0,1,0,0,8'hC3, 2'b11,0,8'h00,1,8'd2));
        tbl.push_back(mk(0,0,0,1,0,0,8'hC3, 2'b00,0,8'h00,0,8'd2));
        tbl.push_back(mk(1,0,0,1,0,0,8'hC3, 2'b01,0,8'h00,0,8'd2));
        tbl.push_back(mk(0,0,0,1,1,0,8'h00, 2'b00,0,8'h00,0,8'd2));
        tbl.push_back(mk(0,0,1,1,1,0,8'h00, 2'b00,0,8'h00,0,8'd2));
        tbl.push_back(mk(0,0,1,1,1,0,8'h00, 2'b00,0,8'h00,0,8'd2));
        tbl.push_back(mk(0,0,1,1,0,0,8'h77, 2'b00,0,8'h00,0,8'd2));
        tbl.push_back(mk(0,0,1,1,0,0,8'h77, 2'b00,0,8'h00,0,8'd2));

        // reset state
        #12;
        check("reset_state", {mode, rd_valid, rd_data, wr_drop, pop_count}, {2'b11, 1'b0, 8'h00, 1'b0, 8'h00});
        @(negedge gclk);
        rst_n = 1'b1;

        foreach (tbl[i]) begin
            wr_req = tbl[i].wr; flush_req = tbl[i].fl; pop_btn = tbl[i].btn; rd_ready = tbl[i].rdy;
            fifo_empty = tbl[i].emp; fifo_full = tbl[i].full; fifo_head = tbl[i].head;
            step();
            check($sformatf("vec%0d", i), pack(mode, rd_valid, tbl[i].e_vld ? rd_data : 8'h00, wr_drop, pop_count),
                  pack(tbl[i].e_mode, tbl[i].e_vld, tbl[i].e_data, tbl[i].e_drop, tbl[i].e_pc));
        end

        // reset while a pop is in flight
        wr_req = 0; flush_req = 0; pop_btn = 0; rd_ready = 1; fifo_empty = 0; fifo_full = 0; fifo_head = 8'h5A;
        step(); step();
        pop_btn = 1;
        begin
            int n = 0;
            while (mode != 2'b10 && n < 10) begin step(); n++; end
            check("pop_before_reset_seen", {31'h0, n < 10}, 32'h1);
        end
        #2 rst_n = 1'b0;
        #1 check("reset_mid_pop", {mode, rd_valid, pop_count}, {2'b11, 1'b0, 8'h00});
        pop_btn = 0;
        @(negedge gclk);
        rst_n = 1'b1;
        step();
        check("flush_replay_1", {30'h0, mode}, {30'h0, 2'b11});
        step();
        check("flush_replay_2", {30'h0, mode}, {30'h0, 2'b00});

        // pop_count wrap: 256 manual pops
        for (int p = 0; p < 256; p++) begin
            pop_btn = 1;
            repeat (3) step();
            pop_btn = 0;
            repeat (3) step();
            if (p == 254) check("pop_count_255", {24'h0, pop_count}, 32'd255);
        end
        check("pop_count_wrap", {24'h0, pop_count}, 32'd0);

        // random closed-loop traffic against the model
        rst_n = 1'b0;
        wr_req = 0; flush_req = 0; pop_btn = 0; rd_ready = 1;
        q.delete();
        drive_fifo_flags();
        model_reset();
        @(negedge gclk);
        rst_n = 1'b1;
        for (int c = 0; c < 3000; c++) begin
            logic [1:0] cur_mode;
            wr_req    = ($urandom_range(0, 2) == 0);
            flush_req = ($urandom_range(0, 49) == 0);
            rd_ready  = ($urandom_range(0, 1) == 0);
            if ($urandom_range(0, 3) == 0) pop_btn = ~pop_btn;
            drive_fifo_flags();
            cur_mode = m_mode;
            model_step();
            step();
            check($sformatf("rand%0d", c), pack(mode, rd_valid, m_vld ? rd_data : 8'h00, wr_drop, pop_count),
                  pack(m_mode, m_vld, m_data, m_drop, m_pc));
            case (cur_mode)
                2'b01: if (q.size() < 8) q.push_back(8'($urandom));
                2'b10: if (q.size() > 0) void'(q.pop_front());
                2'b11: q.delete();
                default: ;
            endcase
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
